// File: rtl/psum_drain.sv
`timescale 1ns/1ps
// Purpose : snapshot all PSUM lanes on completion, requantize (shift, round toward zero, ReLU, saturate), stream OUT_LANES per beat.
// Latency : first beat valid the cycle after capture; o_Done one cycle after the last beat is accepted.
// Backpr. : i_Out_Rdy low holds beat, data and address indefinitely; a new snapshot is accepted only when idle or on the last-beat handshake.
//
// Ports:
//   i_CLK, i_RSTn              clock, asynchronous active-low reset
//   i_Psum_Vld/o_Psum_Rdy      snapshot handshake; i_Psum carries N_LANE packed signed lanes
//   i_Shift, i_Relu            requant controls, latched together with the snapshot
//   i_Addr_Clr                 synchronous clear of the output address (wins over increment)
//   o_Out_Vld/i_Out_Rdy        beat handshake; o_Out_Data holds OUT_LANES packed signed results
//   o_Out_Addr                 output buffer write address, wraps modulo 2^ADDR_W
//   o_Done                     one-cycle pulse after the last beat of a snapshot is accepted
//   o_Overflow                 sticky: a snapshot was offered while we could not take it
module psum_drain #(
   parameter int N_LANE    = 16,
   parameter int BITS_PSUM = 32,
   parameter int BITS_OUT  = 8,
   parameter int OUT_LANES = 4,
   parameter int SHIFT_W   = 5,
   parameter int ADDR_W    = 10
) (
   input  logic                            i_CLK,
   input  logic                            i_RSTn,
   input  logic                            i_Psum_Vld,
   input  logic [N_LANE*BITS_PSUM-1:0]     i_Psum,
   output logic                            o_Psum_Rdy,
   input  logic [SHIFT_W-1:0]              i_Shift,
   input  logic                            i_Relu,
   input  logic                            i_Addr_Clr,
   output logic                            o_Out_Vld,
   input  logic                            i_Out_Rdy,
   output logic [OUT_LANES*BITS_OUT-1:0]   o_Out_Data,
   output logic [ADDR_W-1:0]               o_Out_Addr,
   output logic                            o_Done,
   output logic                            o_Overflow
);

   // N_LANE is expected to be a multiple of OUT_LANES; NB is the beat count per snapshot.
   localparam int NB     = N_LANE / OUT_LANES;
   localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;

   // Saturation bounds expressed at the partial-sum width so comparisons stay signed.
   localparam logic signed [BITS_PSUM-1:0] SAT_MAX = BITS_PSUM'((2 ** (BITS_OUT - 1)) - 1);
   localparam logic signed [BITS_PSUM-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [BEAT_W-1:0]             beat_q;
   logic signed [BITS_PSUM-1:0]   snap_q [N_LANE];
   logic [SHIFT_W-1:0]            shift_q;
   logic                          relu_q;
   logic [ADDR_W-1:0]             addr_q;
   logic                          done_q;
   logic                          ovf_q;

   logic                          out_vld;
   logic                          out_hs;
   logic                          last_beat;
   logic                          psum_rdy;
   logic                          capture;
   logic                          last_hs;

   logic signed [BITS_PSUM-1:0]   lane_sel [OUT_LANES];
   logic [OUT_LANES*BITS_OUT-1:0] out_data;

   // Arithmetic shift floors; negative values with discarded non-zero bits are
   // bumped by one so the overall rounding is toward zero. Shift 0 leaves the
   // mask empty, so x passes through untouched before ReLU/saturation.
   function automatic logic [BITS_OUT-1:0] requant(
      input logic signed [BITS_PSUM-1:0] x,
      input logic [SHIFT_W-1:0]          sh,
      input logic                        relu
   );
      logic signed [BITS_PSUM-1:0] y;
      logic [BITS_PSUM-1:0]        low_mask;
      logic [BITS_OUT-1:0]         r;
      y        = x >>> sh;
      low_mask = ~({BITS_PSUM{1'b1}} << sh);
      if (x[BITS_PSUM-1] && ((x & low_mask) != '0)) begin
         y = y + {{(BITS_PSUM-1){1'b0}}, 1'b1};
      end
      if (relu && y[BITS_PSUM-1]) begin
         y = '0;
      end
      if (y > SAT_MAX) begin
         r = SAT_MAX[BITS_OUT-1:0];
      end else if (y < SAT_MIN) begin
         r = SAT_MIN[BITS_OUT-1:0];
      end else begin
         r = y[BITS_OUT-1:0];
      end
      return r;
   endfunction

   // Handshake terms shared by the FSM and the datapath.
   always_comb begin
      out_vld   = (state_q == DRAIN);
      out_hs    = out_vld & i_Out_Rdy;
      last_beat = (beat_q == BEAT_W'(NB - 1));
      last_hs   = out_hs & last_beat;
      // Accepting on the last-beat handshake lets consecutive snapshots drain without a bubble.
      psum_rdy  = (state_q == IDLE) | last_hs;
      capture   = i_Psum_Vld & psum_rdy;
   end

   // FSM: state register
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (capture) state_d = DRAIN;
         end
         DRAIN: begin
            if (last_hs) state_d = capture ? DRAIN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot, requant controls, beat/address counters and status flags.
   // The snapshot is reset too so that o_Out_Data reads zero out of reset.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         for (int k = 0; k < N_LANE; k++) begin
            snap_q[k] <= '0;
         end
         shift_q <= '0;
         relu_q  <= 1'b0;
         beat_q  <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (capture) begin
            for (int k = 0; k < N_LANE; k++) begin
               snap_q[k] <= i_Psum[k*BITS_PSUM +: BITS_PSUM];
            end
            shift_q <= i_Shift;
            relu_q  <= i_Relu;
         end

         if (capture || last_hs) begin
            beat_q <= '0;
         end else if (out_hs) begin
            beat_q <= beat_q + 1'b1;
         end

         // Clear wins over the increment of the same cycle.
         if (i_Addr_Clr) begin
            addr_q <= '0;
         end else if (out_hs) begin
            addr_q <= addr_q + 1'b1;
         end

         done_q <= last_hs;

         if (i_Psum_Vld && !psum_rdy) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Beat data depends only on registered state, so it holds steady through a stall.
   always_comb begin
      for (int j = 0; j < OUT_LANES; j++) begin
         lane_sel[j] = '0;
      end
      for (int b = 0; b < NB; b++) begin
         if (beat_q == BEAT_W'(b)) begin
            for (int j = 0; j < OUT_LANES; j++) begin
               lane_sel[j] = snap_q[b*OUT_LANES + j];
            end
         end
      end
      out_data = '0;
      for (int j = 0; j < OUT_LANES; j++) begin
         out_data[j*BITS_OUT +: BITS_OUT] = requant(lane_sel[j], shift_q, relu_q);
      end
   end

   assign o_Psum_Rdy = psum_rdy;
   assign o_Out_Vld  = out_vld;
   assign o_Out_Data = out_data;
   assign o_Out_Addr = addr_q;
   assign o_Done     = done_q;
   assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_psum_drain.sv
`timescale 1ns/1ps
module tb_psum_drain;

   localparam int N_LANE = 16;
   localparam int BP     = 32;
   localparam int OL     = 4;
   localparam int BO     = 8;
   localparam int SW     = 5;
   localparam int AW     = 10;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 i_Psum_Vld;
   logic [N_LANE*BP-1:0] i_Psum;
   logic                 o_Psum_Rdy;
   logic [SW-1:0]        i_Shift;
   logic                 i_Relu;
   logic                 i_Addr_Clr;
   logic                 o_Out_Vld;
   logic                 i_Out_Rdy;
   logic [OL*BO-1:0]     o_Out_Data;
   logic [AW-1:0]        o_Out_Addr;
   logic                 o_Done;
   logic                 o_Overflow;

   psum_drain dut (
      .i_CLK      (clk),
      .i_RSTn     (rst_n),
      .i_Psum_Vld (i_Psum_Vld),
      .i_Psum     (i_Psum),
      .o_Psum_Rdy (o_Psum_Rdy),
      .i_Shift    (i_Shift),
      .i_Relu     (i_Relu),
      .i_Addr_Clr (i_Addr_Clr),
      .o_Out_Vld  (o_Out_Vld),
      .i_Out_Rdy  (i_Out_Rdy),
      .o_Out_Data (o_Out_Data),
      .o_Out_Addr (o_Out_Addr),
      .o_Done     (o_Done),
      .o_Overflow (o_Overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OL*BO-1:0] d;
      logic [AW-1:0]    a;
   } beat_t;

   beat_t         sb[$];
   int            total = 0;
   int            bad = 0;
   int            done_cnt = 0;
   int            lv [N_LANE];
   logic [AW-1:0] exp_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_one(input logic [OL*BO-1:0] d, input logic [AW-1:0] a);
      beat_t b;
      b.d = d;
      b.a = a;
      sb.push_back(b);
   endtask

   task automatic push_beats(input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
      push_one(d0, exp_addr); exp_addr = exp_addr + 1'b1;
      push_one(d1, exp_addr); exp_addr = exp_addr + 1'b1;
      push_one(d2, exp_addr); exp_addr = exp_addr + 1'b1;
      push_one(d3, exp_addr); exp_addr = exp_addr + 1'b1;
   endtask

   task automatic lanes_ramp();
      for (int k = 0; k < N_LANE; k++) lv[k] = 1000 * k;
   endtask

   task automatic lanes_neg();
      for (int k = 0; k < N_LANE; k++) lv[k] = 0;
      lv[0] = -17;  lv[1] = -16;  lv[2] = -15;   lv[3] = 0;
      lv[4] = 2047; lv[5] = -2047; lv[6] = -2064; lv[7] = 2032;
   endtask

   task automatic lanes_sat();
      for (int k = 0; k < N_LANE; k++) lv[k] = 0;
      lv[0] = -100000; lv[1] = 100000; lv[2] = -128; lv[3] = 127;
      lv[4] = -129;    lv[5] = 128;    lv[6] = 5;    lv[7] = -5;
   endtask

   task automatic drive_snap(input logic [SW-1:0] sh, input logic rl);
      for (int k = 0; k < N_LANE; k++) i_Psum[k*BP +: BP] = lv[k];
      i_Shift    = sh;
      i_Relu     = rl;
      i_Psum_Vld = 1'b1;
   endtask

   // Called one step after a rising edge while idle; returns in the first beat cycle.
   task automatic capture(input logic [SW-1:0] sh, input logic rl);
      drive_snap(sh, rl);
      @(negedge clk);
      chk("cap_rdy", 64'(o_Psum_Rdy), 64'd1);
      @(posedge clk); #1;
      i_Psum_Vld = 1'b0;
      i_Shift    = ~sh;
      i_Relu     = ~rl;
      for (int k = 0; k < N_LANE; k++) i_Psum[k*BP +: BP] = $urandom();
   endtask

   task automatic wait_idle(input string name);
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!o_Out_Vld) break;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL %s: drain still active after %0d cycles, expected idle", name, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic addr_clr();
      i_Addr_Clr = 1'b1;
      @(posedge clk); #1;
      i_Addr_Clr = 1'b0;
      exp_addr   = '0;
   endtask

   // Monitor: every presented beat must match the scoreboard head (so a stalled
   // beat is checked every cycle); the head is retired on handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_Done) done_cnt++;
         if (o_Out_Vld) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL beat_unexpected: got addr %0d data %h, expected no beat", o_Out_Addr, o_Out_Data);
            end else begin
               chk("beat_data", 64'(o_Out_Data), 64'(sb[0].d));
               chk("beat_addr", 64'(o_Out_Addr), 64'(sb[0].a));
               if (i_Out_Rdy) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int n;
      int acc;
      int g;
      logic [3:0] pat;

      rst_n      = 1'b0;
      i_Psum_Vld = 1'b0;
      i_Psum     = '0;
      i_Shift    = '0;
      i_Relu     = 1'b0;
      i_Addr_Clr = 1'b0;
      i_Out_Rdy  = 1'b1;
      exp_addr   = '0;

      #12;
      chk("rst_vld",  64'(o_Out_Vld),  64'd0);
      chk("rst_data", 64'(o_Out_Data), 64'd0);
      chk("rst_addr", 64'(o_Out_Addr), 64'd0);
      chk("rst_done", 64'(o_Done),     64'd0);
      chk("rst_ovf",  64'(o_Overflow), 64'd0);
      chk("rst_rdy",  64'(o_Psum_Rdy), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1000*k, shift 4: 62, 125, then saturation at 127
      lanes_ramp();
      push_beats(32'h7F7D3E00, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F);
      d0 = done_cnt;
      capture(5'd4, 1'b0);
      for (n = 1; n < 20; n++) begin
         @(negedge clk);
         if (o_Done) break;
         @(posedge clk); #1;
      end
      chk("done_latency", 64'(n), 64'd5);
      @(posedge clk); #1;
      chk("done_cnt_t1", 64'(done_cnt - d0), 64'd1);

      // round toward zero and saturation, shift 4, relu off then on
      lanes_neg();
      push_beats(32'h0000FFFF, 32'h7F80817F, 32'h0, 32'h0);
      capture(5'd4, 1'b0);
      wait_idle("idle_t2a");
      push_beats(32'h0, 32'h7F00007F, 32'h0, 32'h0);
      capture(5'd4, 1'b1);
      wait_idle("idle_t2b");
      lanes_sat();
      push_beats(32'h7F807F80, 32'hFB057F80, 32'h0, 32'h0);
      capture(5'd0, 1'b0);
      wait_idle("idle_t2c");

      // ready pattern 1,0,0,1: stalled beats hold, addresses 0..3
      addr_clr();
      lanes_ramp();
      push_beats(32'h2E1F0F00, 32'h6D5D4E3E, 32'h7F7F7F7D, 32'h7F7F7F7F);
      d0  = done_cnt;
      acc = 0;
      pat = 4'b1001;
      capture(5'd6, 1'b0);
      for (n = 0; n < 40; n++) begin
         i_Out_Rdy = pat[n % 4];
         @(negedge clk);
         if (!o_Out_Vld) break;
         if (i_Out_Rdy) acc++;
         @(posedge clk); #1;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL toggle_timeout: drain active after %0d cycles, expected idle", n);
      end
      i_Out_Rdy = 1'b1;
      @(posedge clk); #1;
      chk("toggle_beats", 64'(acc), 64'd4);
      chk("toggle_done",  64'(done_cnt - d0), 64'd1);

      // back-to-back snapshots: 8 contiguous beats, two done pulses
      addr_clr();
      lanes_ramp();
      push_beats(32'h7F7D3E00, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F);
      d0 = done_cnt;
      capture(5'd4, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         if (c == 4) begin
            lanes_neg();
            push_beats(32'h0000FFFF, 32'h7F80817F, 32'h0, 32'h0);
            drive_snap(5'd4, 1'b0);
         end
         @(negedge clk);
         chk("b2b_vld", 64'(o_Out_Vld), 64'd1);
         if (c == 4) chk("b2b_rdy", 64'(o_Psum_Rdy), 64'd1);
         @(posedge clk); #1;
         if (c == 4) begin
            i_Psum_Vld = 1'b0;
            i_Shift    = 5'd31;
         end
      end
      wait_idle("idle_b2b");
      chk("b2b_done", 64'(done_cnt - d0), 64'd2);

      // offered snapshot during beat 1 is dropped and flagged
      addr_clr();
      lanes_ramp();
      push_beats(32'h2E1F0F00, 32'h6D5D4E3E, 32'h7F7F7F7D, 32'h7F7F7F7F);
      capture(5'd6, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < N_LANE; k++) i_Psum[k*BP +: BP] = 32'h7FFFFFFF;
      i_Psum_Vld = 1'b1;
      @(negedge clk);
      chk("ovf_rdy",    64'(o_Psum_Rdy), 64'd0);
      chk("ovf_before", 64'(o_Overflow), 64'd0);
      @(posedge clk); #1;
      i_Psum_Vld = 1'b0;
      chk("ovf_set", 64'(o_Overflow), 64'd1);
      wait_idle("idle_ovf");
      chk("ovf_sticky",  64'(o_Overflow), 64'd1);
      chk("ovf_no_cap",  64'(o_Out_Vld),  64'd0);

      // 256 chained zero snapshots: addresses run 4..1023 then wrap to 0..3
      i_Psum     = '0;
      i_Shift    = '0;
      i_Relu     = 1'b0;
      i_Psum_Vld = 1'b1;
      n = 0;
      g = 0;
      while (n < 256 && g < 3000) begin
         @(negedge clk);
         if (o_Psum_Rdy) begin
            n++;
            push_beats(32'h0, 32'h0, 32'h0, 32'h0);
         end
         g++;
         @(posedge clk); #1;
      end
      i_Psum_Vld = 1'b0;
      chk("wrap_caps", 64'(n), 64'd256);
      wait_idle("idle_wrap");

      // clear coinciding with the beat-1 handshake: next beat goes to address 0
      lanes_sat();
      push_one(32'h7F807F80, exp_addr);
      push_one(32'hFB057F80, exp_addr + 1'b1);
      push_one(32'h0, 10'd0);
      push_one(32'h0, 10'd1);
      exp_addr = 10'd2;
      capture(5'd0, 1'b0);
      @(posedge clk); #1;
      i_Addr_Clr = 1'b1;
      @(posedge clk); #1;
      i_Addr_Clr = 1'b0;
      wait_idle("idle_clr");

      // reset during beat 2: everything back to reset values, no done
      lanes_ramp();
      push_beats(32'h7F7D3E00, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F);
      d0 = done_cnt;
      capture(5'd4, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_vld",  64'(o_Out_Vld),  64'd0);
      chk("mid_rst_addr", 64'(o_Out_Addr), 64'd0);
      chk("mid_rst_data", 64'(o_Out_Data), 64'd0);
      chk("mid_rst_done", 64'(o_Done),     64'd0);
      chk("mid_rst_ovf",  64'(o_Overflow), 64'd0);
      chk("mid_rst_rdy",  64'(o_Psum_Rdy), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
      exp_addr = '0;
      lanes_sat();
      push_beats(32'h7F807F80, 32'hFB057F80, 32'h0, 32'h0);
      capture(5'd0, 1'b0);
      wait_idle("idle_post_rst");
      chk("post_rst_done", 64'(done_cnt - d0), 64'd1);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
